operand_stream_bank: RTL and testbench

- Parametrised operand store and sequencer for the matrix-multiply accelerator; generalises the fixed 3x3, 4-bit operand memory bank.
- Accepts W (M x K) then X (K x N) row-major over a valid/ready input stream.
- Then streams one outer-product step per accepted beat to a MAX_DIM x MAX_DIM MAC array: column k of W and row k of X, with per-MAC enable/clear masks and a done indication.

---
 rtl/operand_stream_bank_if.sv | 42 ++++
 rtl/operand_stream_bank.sv | 165 ++++++++++++++++
 tb/tb_operand_stream_bank.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stream_bank_if.sv
// operand_stream_bank_if: job config, operand input stream and
// outer-product step stream between the bank and its neighbours.
interface operand_stream_bank_if #(
   parameter int DW      = 4,
   parameter int MAX_DIM = 3,
   parameter int DIM_W   = 2
);
   logic                       start;
   logic [DIM_W-1:0]           row_w;
   logic [DIM_W-1:0]           col_w;
   logic [DIM_W-1:0]           row_x;
   logic [DIM_W-1:0]           col_x;
   logic                       in_valid;
   logic                       in_ready;
   logic [DW-1:0]              in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [MAX_DIM*DW-1:0]      out_w;
   logic [MAX_DIM*DW-1:0]      out_x;
   logic                       out_last;
   logic [MAX_DIM*MAX_DIM-1:0] mac_en;
   logic [MAX_DIM*MAX_DIM-1:0] mac_clear;
   logic                       busy;
   logic                       done;
   logic                       cfg_err;

   modport master (
      output start, row_w, col_w, row_x, col_x,
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_w, out_x,
      input  out_last, mac_en, mac_clear,
      input  busy, done, cfg_err
   );

   modport slave (
      input  start, row_w, col_w, row_x, col_x,
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_w, out_x,
      output out_last, mac_en, mac_clear,
      output busy, done, cfg_err
   );
endinterface

// File: rtl/operand_stream_bank.sv
// operand_stream_bank: W/X operand store and outer-product step
// sequencer feeding a MAX_DIM x MAX_DIM MAC array.
module operand_stream_bank #(
   parameter int DW      = 4,
   parameter int MAX_DIM = 3,
   parameter int DIM_W   = 2
) (
   input logic clk,
   input logic rst_n,
   operand_stream_bank_if.slave bus
);
   localparam int NE = MAX_DIM * MAX_DIM;
   localparam int AW = (NE > 1) ? $clog2(NE) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_X, STREAM, DONE
   } state_t;

   state_t                state;
   logic [DIM_W-1:0]      dm, dk, dn, step;
   logic [AW-1:0]         cnt;
   logic [DW-1:0]         w_mem [NE];
   logic [DW-1:0]         x_mem [NE];
   logic                  done_r, err_r;
   logic [NE-1:0]         clear_r, mask, new_mask;
   logic                  dims_ok, in_xfer, out_xfer;
   logic                  loading, streaming;
   logic                  last_el, last_step;
   logic [MAX_DIM*DW-1:0] lane_w, lane_x;
   int                    tot_w, tot_x;

   function automatic logic [NE-1:0] region(
      input logic [DIM_W-1:0] m,
      input logic [DIM_W-1:0] n
   );
      logic [NE-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_DIM; i++)
         for (int j = 0; j < MAX_DIM; j++)
            r[i*MAX_DIM+j] = (i < int'(m)) && (j < int'(n));
      return r;
   endfunction

   assign loading   = (state == LOAD_W) || (state == LOAD_X);
   assign streaming = (state == STREAM);
   assign in_xfer   = bus.in_valid && loading;
   assign out_xfer  = streaming && bus.out_ready;
   assign mask      = region(dm, dn);
   assign new_mask  = region(bus.row_w, bus.col_x);
   assign last_step = streaming && (step == dk - 1'b1);

   always_comb begin
      dims_ok = (bus.row_w != '0) && (bus.col_w != '0)
             && (bus.col_x != '0)
             && (int'(bus.row_w) <= MAX_DIM)
             && (int'(bus.col_w) <= MAX_DIM)
             && (int'(bus.col_x) <= MAX_DIM)
             && (bus.col_w == bus.row_x);
      tot_w = int'(dm) * int'(dk);
      tot_x = int'(dk) * int'(dn);
      if (state == LOAD_W)
         last_el = (int'(cnt) == tot_w - 1);
      else
         last_el = (int'(cnt) == tot_x - 1);
   end

   // Lanes outside the active region read as zero, so stale memory never leaks.
   always_comb begin
      lane_w = '0;
      lane_x = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (streaming && i < int'(dm))
            lane_w[i*DW +: DW] =
               w_mem[AW'(i * int'(dk) + int'(step))];
         if (streaming && i < int'(dn))
            lane_x[i*DW +: DW] =
               x_mem[AW'(int'(step) * int'(dn) + i)];
      end
   end

   always_ff @(posedge clk) begin
      if (in_xfer && state == LOAD_W)
         w_mem[cnt] <= bus.in_data;
      if (in_xfer && state == LOAD_X)
         x_mem[cnt] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dm      <= '0;
         dk      <= '0;
         dn      <= '0;
         cnt     <= '0;
         step    <= '0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         clear_r <= '0;
      end else begin
         clear_r <= '0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  done_r <= 1'b0;
                  if (dims_ok) begin
                     dm      <= bus.row_w;
                     dk      <= bus.col_w;
                     dn      <= bus.col_x;
                     err_r   <= 1'b0;
                     clear_r <= new_mask;
                     cnt     <= '0;
                     state   <= LOAD_W;
                  end else begin
                     err_r <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            LOAD_W: begin
               if (in_xfer) begin
                  if (last_el) begin
                     cnt   <= '0;
                     state <= LOAD_X;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LOAD_X: begin
               if (in_xfer) begin
                  if (last_el) begin
                     cnt   <= '0;
                     step  <= '0;
                     state <= STREAM;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (out_xfer) begin
                  if (last_step) begin
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     step <= step + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = loading;
   assign bus.out_valid = streaming;
   assign bus.out_w     = lane_w;
   assign bus.out_x     = lane_x;
   assign bus.out_last  = last_step;
   assign bus.mac_en    = out_xfer ? mask : '0;
   assign bus.mac_clear = clear_r;
   assign bus.busy      = loading || streaming;
   assign bus.done      = done_r;
   assign bus.cfg_err   = err_r;
endmodule

// File: tb/tb_operand_stream_bank.sv
// tb_operand_stream_bank: randomized jobs against a matrix-level model,
// with a queue scoreboard checked by an independent monitor.
module tb_operand_stream_bank;
   typedef struct packed {
      logic [11:0] w;
      logic [11:0] x;
      logic        last;
      logic [8:0]  en;
   } step_t;

   logic  clk;
   logic  rst_n;
   int    compared;
   int    mismatched;
   int    writes;
   int    pulses;
   step_t sb [$];
   step_t exp_s;
   logic [3:0] wm [3][3];
   logic [3:0] xm [3][3];

   operand_stream_bank_if #(.DW(4), .MAX_DIM(3), .DIM_W(2)) bus ();
   operand_stream_bank_if #(.DW(4), .MAX_DIM(3), .DIM_W(3)) bus2 ();

   operand_stream_bank #(.DW(4), .MAX_DIM(3), .DIM_W(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   operand_stream_bank #(.DW(4), .MAX_DIM(3), .DIM_W(3)) dut_big (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [8:0] mask_of(input int m, input int n);
      logic [8:0] r;
      r = '0;
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++)
            r[i*3+j] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] elem(input int idx, input int m,
                                       input int k, input int n);
      if (idx < m * k)
         return wm[idx / k][idx % k];
      return xm[(idx - m * k) / n][(idx - m * k) % n];
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid && bus.in_ready) writes++;
         if (bus.mac_en != '0) pulses++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_step: got step with empty queue");
            end else begin
               exp_s = sb.pop_front();
               chk("step", {bus.out_w, bus.out_x, bus.out_last,
                            bus.mac_en}, exp_s);
            end
         end else if (bus.out_valid) begin
            chk("stall_en", bus.mac_en, 0);
            if (sb.size() > 0)
               chk("stall_hold", {bus.out_w, bus.out_x},
                   {sb[0].w, sb[0].x});
         end else begin
            chk("idle_en", bus.mac_en, 0);
         end
      end
   end

   task automatic do_start(input int m, input int k,
                           input int kx, input int n);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.row_w = 2'(m);
      bus.col_w = 2'(k);
      bus.row_x = 2'(kx);
      bus.col_x = 2'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_job(input int m, input int k, input int n,
                          input bit gaps, input int st_step,
                          input int st_len, input bit rnd);
      int n_el, idx, cyc, rdy, s, st, w0, p0;
      bit tog;
      step_t e;
      for (int t = 0; t < k; t++) begin
         e = '0;
         for (int i = 0; i < m; i++) e.w[i*4 +: 4] = wm[i][t];
         for (int j = 0; j < n; j++) e.x[j*4 +: 4] = xm[t][j];
         e.last = (t == k - 1);
         e.en = mask_of(m, n);
         sb.push_back(e);
      end
      w0 = writes;
      p0 = pulses;
      do_start(m, k, k, n);
      chk("clear", bus.mac_clear, mask_of(m, n));
      chk("busy", bus.busy, 1);
      chk("cfg_ok", {bus.cfg_err, bus.done}, 0);
      n_el = m * k + k * n;
      idx = 0; cyc = 0; rdy = 0; tog = 1'b0;
      while (idx < n_el && cyc < 200) begin
         tog = ~tog;
         bus.in_valid = gaps ? tog : 1'b1;
         bus.in_data = elem(idx, m, k, n);
         if (bus.in_ready) rdy++;
         if (bus.in_valid && bus.in_ready) idx++;
         cyc++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("load_done", idx, n_el);
      if (!gaps) chk("ready_cyc", rdy, n_el);
      chk("ready_low", bus.in_ready, 0);
      chk("clear_once", bus.mac_clear, 0);
      s = 0; st = 0; cyc = 0;
      while (s < k && cyc < 100) begin
         if (s == st_step && st < st_len) begin
            bus.out_ready = 1'b0;
            st++;
         end else begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (bus.out_valid && bus.out_ready) s++;
         cyc++;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      chk("steps", s, k);
      chk("done", {bus.done, bus.busy, bus.out_valid}, 3'b100);
      chk("writes", writes - w0, n_el);
      chk("pulses", pulses - p0, k);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic cfg_bad(input int m, input int k,
                          input int kx, input int n);
      do_start(m, k, kx, n);
      chk("cfg_err", {bus.cfg_err, bus.in_ready, bus.busy, bus.done},
          4'b1000);
      @(posedge clk); #1;
      chk("cfg_idle", {bus.in_ready, bus.busy, bus.out_valid}, 0);
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            wm[i][j] = 4'(i * 3 + j + 1);
            xm[i][j] = 4'(9 - (i * 3 + j));
         end
   endtask

   task automatic fill_rnd();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            wm[i][j] = 4'($urandom_range(0, 15));
            xm[i][j] = 4'($urandom_range(0, 15));
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_el, idx, w0;
      compared = 0; mismatched = 0; writes = 0; pulses = 0;
      bus.start = 0; bus.row_w = 0; bus.col_w = 0;
      bus.row_x = 0; bus.col_x = 0; bus.in_valid = 0;
      bus.in_data = 0; bus.out_ready = 0;
      bus2.start = 0; bus2.row_w = 0; bus2.col_w = 0;
      bus2.row_x = 0; bus2.col_x = 0; bus2.in_valid = 0;
      bus2.in_data = 0; bus2.out_ready = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_ctl", {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                      bus.cfg_err, bus.out_last}, 0);
      chk("rst_vec", {bus.mac_en, bus.mac_clear, bus.out_w, bus.out_x}, 0);

      bus2.row_w = 3'd4; bus2.col_w = 3'd3;
      bus2.row_x = 3'd3; bus2.col_x = 3'd3;
      @(posedge clk); #1 bus2.start = 1'b1;
      @(posedge clk); #1 bus2.start = 1'b0;
      chk("big_err", {bus2.cfg_err, bus2.in_ready, bus2.busy}, 3'b100);
      bus2.row_w = 3'd3;
      @(posedge clk); #1 bus2.start = 1'b1;
      @(posedge clk); #1 bus2.start = 1'b0;
      chk("big_ok", {bus2.cfg_err, bus2.in_ready, bus2.busy}, 3'b011);

      fill_seq();
      run_job(3, 3, 3, 1'b0, -1, 0, 1'b0);
      cfg_bad(3, 2, 3, 3);
      cfg_bad(0, 3, 3, 3);

      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            wm[i][j] = 4'(i * 3 + j + 1);
            xm[i][j] = 4'(i * 2 + j + 1);
         end
      run_job(2, 3, 2, 1'b0, -1, 0, 1'b0);

      fill_rnd();
      run_job(3, 3, 3, 1'b0, 1, 4, 1'b0);

      fill_seq();
      w0 = writes;
      do_start(3, 3, 3, 3);
      idx = 0; n_el = 0;
      while (idx < 5 && n_el < 50) begin
         bus.in_valid = 1'b1;
         bus.in_data = wm[idx / 3][idx % 3];
         if (bus.in_ready) idx++;
         n_el++;
         @(posedge clk); #1;
      end
      chk("abort_writes", writes - w0, 5);
      #2 rst_n = 1'b0;
      #1;
      bus.in_valid = 1'b0;
      chk("abort_ctl", {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                        bus.cfg_err, bus.out_last}, 0);
      chk("abort_vec", {bus.mac_en, bus.mac_clear, bus.out_w, bus.out_x},
          0);
      @(negedge clk);
      rst_n = 1'b1;
      wm[0][0] = 4'd7;
      xm[0][0] = 4'd3;
      run_job(1, 1, 1, 1'b0, -1, 0, 1'b0);

      fill_seq();
      run_job(3, 3, 3, 1'b1, -1, 0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         fill_rnd();
         run_job($urandom_range(1, 3), $urandom_range(1, 3),
                 $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
      end
      cfg_bad(2, 1, 2, 2);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
